// File: rtl/pattern_det_param.sv
// Serial pattern detector: compares the last PAT_LEN accepted symbols against a programmable pattern.
// Latency: match pulse is registered, high on the cycle after the final matching symbol is accepted.
// Backpressure: none; a symbol is taken on every edge with valid_i high, idle cycles only pause history.
module pattern_det_param #(
    parameter int SYM_W = 1,
    parameter int PAT_LEN = 5,
    parameter logic [PAT_LEN*SYM_W-1:0] PAT_DEFAULT = 5'b00101,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SYM_W-1:0]         d_i,
    input  logic                     valid_i,
    input  logic                     overlap_i,
    input  logic                     pat_load_i,
    input  logic [PAT_LEN*SYM_W-1:0] pat_i,
    input  logic                     clear_i,
    output logic                     pattern,
    output logic [CNT_W-1:0]         match_cnt
);
    localparam int PAT_W  = PAT_LEN * SYM_W;
    localparam int HIST_W = (PAT_LEN - 1) * SYM_W;
    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_LEN - 1);

    // The oldest symbol is shifted out on the same edge it would be compared, so only
    // PAT_LEN-1 symbols are kept; the incoming d_i completes the comparison window.
    logic [HIST_W-1:0] hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
    logic              pattern_q, pattern_d;

    logic [PAT_W-1:0]  window;
    logic              hit;

    always_comb begin
        window      = {hist_q, d_i};
        hit         = valid_i && (fill_q >= FILL_ARM) && (window == pat_q);

        hist_d      = hist_q;
        fill_d      = fill_q;
        pat_d       = pat_q;
        match_cnt_d = match_cnt_q;
        pattern_d   = 1'b0;

        if (pat_load_i) begin
            pat_d  = pat_i;
            fill_d = '0;
        end else if (clear_i) begin
            hist_d      = '0;
            fill_d      = '0;
            match_cnt_d = '0;
        end else if (valid_i) begin
            hist_d = window[HIST_W-1:0];
            if (hit) begin
                pattern_d = 1'b1;
                if (match_cnt_q != {CNT_W{1'b1}}) begin
                    match_cnt_d = match_cnt_q + CNT_W'(1);
                end
                fill_d = overlap_i ? FILL_FULL : '0;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_q      <= '0;
            fill_q      <= '0;
            pat_q       <= PAT_DEFAULT;
            match_cnt_q <= '0;
            pattern_q   <= 1'b0;
        end else begin
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            pat_q       <= pat_d;
            match_cnt_q <= match_cnt_d;
            pattern_q   <= pattern_d;
        end
    end

    assign pattern   = pattern_q;
    assign match_cnt = match_cnt_q;
endmodule

// File: tb/tb_pattern_det_param.sv
// Bench for pattern_det_param: default, 2-bit-symbol and 2-bit-counter instances against a queue model.
module tb_pattern_det_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A (defaults) and C (CNT_W=2) share stimulus.
    logic       a_rst, a_d, a_valid, a_ovl, a_load, a_clr;
    logic [4:0] a_pat;
    logic       a_pattern, c_pattern;
    logic [7:0] a_cnt;
    logic [1:0] c_cnt;

    // Instance B: SYM_W=2, PAT_LEN=3.
    logic       b_rst, b_valid, b_ovl, b_load, b_clr;
    logic [1:0] b_d;
    logic [5:0] b_pat;
    logic       b_pattern;
    logic [7:0] b_cnt;

    pattern_det_param u_dut_a (
        .clk(clk), .rst(a_rst), .d_i(a_d), .valid_i(a_valid), .overlap_i(a_ovl),
        .pat_load_i(a_load), .pat_i(a_pat), .clear_i(a_clr),
        .pattern(a_pattern), .match_cnt(a_cnt)
    );

    pattern_det_param #(.SYM_W(2), .PAT_LEN(3), .PAT_DEFAULT(6'b11_00_10)) u_dut_b (
        .clk(clk), .rst(b_rst), .d_i(b_d), .valid_i(b_valid), .overlap_i(b_ovl),
        .pat_load_i(b_load), .pat_i(b_pat), .clear_i(b_clr),
        .pattern(b_pattern), .match_cnt(b_cnt)
    );

    pattern_det_param #(.CNT_W(2)) u_dut_c (
        .clk(clk), .rst(a_rst), .d_i(a_d), .valid_i(a_valid), .overlap_i(a_ovl),
        .pat_load_i(a_load), .pat_i(a_pat), .clear_i(a_clr),
        .pattern(c_pattern), .match_cnt(c_cnt)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: symbols accepted since the last restart, current pattern, match count.
    bit         m_seq[$];
    logic [4:0] m_pat;
    int         m_cnt;
    logic       m_pulse;

    function automatic logic tail_match();
        int n = m_seq.size();
        if (n < 5) return 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (m_seq[n - 5 + k] != m_pat[4 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic cyc_a(input logic rst_n, input logic vld, input logic d, input logic ovl,
                         input logic ld, input logic [4:0] pat, input logic clr);
        a_rst = rst_n; a_valid = vld; a_d = d; a_ovl = ovl;
        a_load = ld; a_pat = pat; a_clr = clr;
        @(posedge clk);
        m_pulse = 1'b0;
        if (!rst_n) begin
            m_seq.delete(); m_pat = 5'b00101; m_cnt = 0;
        end else if (ld) begin
            m_pat = pat; m_seq.delete();
        end else if (clr) begin
            m_seq.delete(); m_cnt = 0;
        end else if (vld) begin
            m_seq.push_back(d);
            if (m_seq.size() > 5) void'(m_seq.pop_front());
            if (tail_match()) begin
                m_pulse = 1'b1;
                if (m_cnt < 255) m_cnt++;
                if (!ovl) m_seq.delete();
            end
        end
        #1;
    endtask

    task automatic sym(input logic d, input logic ovl);
        cyc_a(1'b1, 1'b1, d, ovl, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic idle();
        cyc_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic reset_a();
        cyc_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic cyc_b(input logic rst_n, input logic vld, input logic [1:0] d);
        b_rst = rst_n; b_valid = vld; b_d = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Dirty the state first so reset has something to clear.
        sym(1'b1, 1'b0); sym(1'b0, 1'b1);
        reset_a(); reset_a();
        cyc_b(1'b0, 1'b1, 2'd3); cyc_b(1'b0, 1'b0, 2'd0);
        n_chk++; if (a_pattern !== 1'b0) $display("FAIL reset_a_pattern got %b exp 0", a_pattern); else n_pass++;
        n_chk++; if (a_cnt !== 8'd0) $display("FAIL reset_a_cnt got %0d exp 0", a_cnt); else n_pass++;
        n_chk++; if (c_cnt !== 2'd0) $display("FAIL reset_c_cnt got %0d exp 0", c_cnt); else n_pass++;
        n_chk++; if (b_pattern !== 1'b0 || b_cnt !== 8'd0)
            $display("FAIL reset_b got pattern=%b cnt=%0d exp 0/0", b_pattern, b_cnt); else n_pass++;
    endtask

    task automatic test_basic();
        logic [4:0] s = 5'b00101;
        reset_a();
        for (int i = 0; i < 5; i++) begin
            sym(s[4 - i], 1'b0);
            n_chk++; if (a_pattern !== (i == 4))
                $display("FAIL basic_pulse sym%0d got %b exp %b", i, a_pattern, (i == 4)); else n_pass++;
        end
        idle();
        n_chk++; if (a_pattern !== 1'b0) $display("FAIL basic_single_cycle got %b exp 0", a_pattern); else n_pass++;
        n_chk++; if (a_cnt !== 8'd1) $display("FAIL basic_cnt got %0d exp 1", a_cnt); else n_pass++;
    endtask

    task automatic test_gap();
        logic [4:0] s = 5'b00101;
        reset_a();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                idle(); idle(); idle();
                n_chk++; if (a_pattern !== 1'b0) $display("FAIL gap_idle got %b exp 0", a_pattern); else n_pass++;
            end
            sym(s[4 - i], 1'b0);
            n_chk++; if (a_pattern !== (i == 4))
                $display("FAIL gap_pulse sym%0d got %b exp %b", i, a_pattern, (i == 4)); else n_pass++;
        end
        n_chk++; if (a_cnt !== 8'd1) $display("FAIL gap_cnt got %0d exp 1", a_cnt); else n_pass++;
    endtask

    task automatic test_load_overlap();
        logic [6:0] s = 7'b1010101;
        logic       exp;
        for (int ov = 1; ov >= 0; ov--) begin
            reset_a();
            cyc_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b10101, 1'b0);
            for (int i = 0; i < 7; i++) begin
                sym(s[6 - i], ov[0]);
                exp = (ov == 1) ? (i == 4 || i == 6) : (i == 4);
                n_chk++; if (a_pattern !== exp)
                    $display("FAIL overlap%0d_pulse sym%0d got %b exp %b", ov, i, a_pattern, exp); else n_pass++;
            end
            n_chk++; if (a_cnt !== ((ov == 1) ? 8'd2 : 8'd1))
                $display("FAIL overlap%0d_cnt got %0d exp %0d", ov, a_cnt, (ov == 1) ? 2 : 1); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] s = 5'b00101;
        reset_a();
        for (int i = 0; i < 3; i++) sym(s[4 - i], 1'b0);
        reset_a();
        for (int i = 3; i < 5; i++) begin
            sym(s[4 - i], 1'b0);
            n_chk++; if (a_pattern !== 1'b0) $display("FAIL rstmid_no_pulse sym%0d got %b exp 0", i, a_pattern); else n_pass++;
        end
        for (int i = 0; i < 5; i++) begin
            sym(s[4 - i], 1'b0);
            n_chk++; if (a_pattern !== (i == 4))
                $display("FAIL rstmid_pulse sym%0d got %b exp %b", i, a_pattern, (i == 4)); else n_pass++;
        end
        n_chk++; if (a_cnt !== 8'd1) $display("FAIL rstmid_cnt got %0d exp 1", a_cnt); else n_pass++;
    endtask

    task automatic test_sat_clear_load();
        logic [4:0] s = 5'b00101;
        int         exp;
        reset_a();
        for (int m = 0; m < 5; m++) begin
            for (int i = 0; i < 5; i++) sym(s[4 - i], 1'b0);
            exp = (m + 1 > 3) ? 3 : m + 1;
            n_chk++; if (c_cnt !== 2'(exp) || c_pattern !== 1'b1)
                $display("FAIL sat_cnt match%0d got cnt=%0d pulse=%b exp %0d/1", m, c_cnt, c_pattern, exp); else n_pass++;
            n_chk++; if (a_cnt !== 8'(m + 1))
                $display("FAIL wide_cnt match%0d got %0d exp %0d", m, a_cnt, m + 1); else n_pass++;
        end
        cyc_a(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
        n_chk++; if (c_cnt !== 2'd0 || a_cnt !== 8'd0 || a_pattern !== 1'b0)
            $display("FAIL clear got c=%0d a=%0d pulse=%b exp 0/0/0", c_cnt, a_cnt, a_pattern); else n_pass++;
        // Symbol presented with the load must not count toward the new pattern.
        cyc_a(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'b11111, 1'b0);
        n_chk++; if (a_pattern !== 1'b0) $display("FAIL load_edge got %b exp 0", a_pattern); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            sym(1'b1, 1'b0);
            n_chk++; if (a_pattern !== (i == 4))
                $display("FAIL load_fill sym%0d got %b exp %b", i, a_pattern, (i == 4)); else n_pass++;
        end
    endtask

    task automatic test_sym2();
        logic [1:0] st [6] = '{2'd3, 2'd0, 2'd2, 2'd3, 2'd0, 2'd1};
        cyc_b(1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 6; i++) begin
            cyc_b(1'b1, 1'b1, st[i]);
            n_chk++; if (b_pattern !== (i == 2))
                $display("FAIL sym2_pulse sym%0d got %b exp %b", i, b_pattern, (i == 2)); else n_pass++;
        end
        n_chk++; if (b_cnt !== 8'd1) $display("FAIL sym2_cnt got %0d exp 1", b_cnt); else n_pass++;
    endtask

    task automatic test_random();
        int         r;
        logic [4:0] p;
        int         c_exp;
        reset_a();
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 199);
            p = 5'($urandom_range(0, 31));
            if (r == 0)
                reset_a();
            else if (r < 4)
                cyc_a(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1, p, 1'b0);
            else if (r < 6)
                cyc_a(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 5'd0, 1'b1);
            else
                cyc_a(1'b1, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b0, 5'd0, 1'b0);
            c_exp = (m_cnt > 3) ? 3 : m_cnt;
            n_chk++; if (a_pattern !== m_pulse || a_cnt !== 8'(m_cnt) || c_cnt !== 2'(c_exp))
                $display("FAIL random cyc%0d got pulse=%b cnt=%0d ccnt=%0d exp %b/%0d/%0d",
                         n, a_pattern, a_cnt, c_cnt, m_pulse, m_cnt, c_exp); else n_pass++;
        end
    endtask

    initial begin
        a_rst = 1'b0; a_d = 1'b0; a_valid = 1'b0; a_ovl = 1'b0; a_load = 1'b0; a_clr = 1'b0; a_pat = 5'd0;
        b_rst = 1'b0; b_d = 2'd0; b_valid = 1'b0; b_ovl = 1'b0; b_load = 1'b0; b_clr = 1'b0; b_pat = 6'd0;
        m_pat = 5'b00101; m_cnt = 0; m_pulse = 1'b0;
        reset_a();
        test_reset();
        test_basic();
        test_gap();
        test_load_overlap();
        test_reset_mid();
        test_sat_clear_load();
        test_sym2();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
